// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the program loader.
// Holds the instruction word geometry, the loader frame header byte and
// the loader FSM state encoding (3 bits).
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WR    = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: serial program loader, the write side of CPU program memory.
//
// Receives frames  HDR, N, N x {hi, lo}, CHK  (CHK = XOR of N and all
// instruction bytes), writes each {hi, lo} word to program memory and
// keeps the CPU in reset until a frame completes with a matching checksum.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. byte_ready depends on state only (low during
// the single write cycle) and never on byte_valid; a byte offered while
// byte_ready is low stays on the bus until it is accepted.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   byte_in/valid     incoming byte stream
//   byte_ready        loader can accept a byte this cycle
//   pm_we/addr/wdata  program memory write port (one-cycle pulse per word)
//   cpu_hold          CPU held in reset while high
//   done / error      result of the last frame, sticky until the next HDR
//   dbg_state         current FSM state, for observation only
module prog_loader
  import cpu_pkg::*;
#(
  parameter int         ADDR_W        = 10,
  parameter logic [7:0] HDR           = LOADER_HDR,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                pm_we,
  output logic [ADDR_W-1:0]   pm_addr,
  output logic [INSTR_W-1:0]  pm_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output loader_state_e       dbg_state
);

  // Largest instruction count that fits in memory without wrapping.
  localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;

  logic              take;
  logic              n_bad;

  assign take  = byte_valid & byte_ready;
  assign n_bad = (byte_in == 8'd0) || ({24'd0, byte_in} > MAX_N);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q;
    error_d = error_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // Only a header byte starts a frame; anything else is dropped.
        if (take && byte_in == HDR) begin
          state_d = COUNT;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
        end
      end
      COUNT: begin
        if (take) begin
          if (n_bad) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            cnt_d   = byte_in;
            chk_d   = byte_in;
            state_d = HI;
          end
        end
      end
      HI: begin
        if (take) begin
          hi_d    = byte_in;
          chk_d   = chk_q ^ byte_in;
          state_d = LO;
        end
      end
      LO: begin
        if (take) begin
          lo_d    = byte_in;
          chk_d   = chk_q ^ byte_in;
          state_d = WR;
        end
      end
      WR: begin
        // The write happens in this cycle; advance for the next word.
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? CHECK : HI;
      end
      CHECK: begin
        if (take) begin
          if (byte_in == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      chk_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // The write strobe comes straight from the state register; reset masks
  // it so a write pending in the reset cycle never reaches memory.
  assign pm_we      = (state_q == WR) && !reset;
  assign pm_addr    = addr_q;
  assign pm_wdata   = {hi_q, lo_q};
  assign byte_ready = (state_q != WR);
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule
